// File: rtl/nothing_pipe_pkg.sv
// nothing_pipe_pkg
//   Shared definitions for the nothing_pipe block: debug message field
//   positions, the formatter FSM state type and the header word builder.
package nothing_pipe_pkg;

  // Payload length field inside the header word.
  localparam int MSG_LEN_LSB = 0;
  localparam int MSG_LEN_MSB = 7;

  // Widest message bus the header builder supports. The header flag sits at
  // bit MSG_WIDTH-1 of the actual bus.
  localparam int MSG_MAX_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } msg_state_e;

  // Builds a header word: flag bit at hdr_bit, length in the low byte.
  // The caller truncates the result to its own bus width.
  function automatic logic [MSG_MAX_WIDTH-1:0] msg_header(input logic [5:0] hdr_bit,
                                                          input logic [7:0] len);
    logic [MSG_MAX_WIDTH-1:0] w;
    w = '0;
    w[MSG_LEN_MSB:MSG_LEN_LSB] = len;
    w[hdr_bit] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/nothing_pipe_if.sv
// nothing_pipe_if
//   Sample stream bundle: data, new-data strobe and metadata.
//   master : drives the stream (producer side)
//   slave  : receives the stream (consumer side)
interface nothing_pipe_if #(
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
);
  logic [WIDTH-1:0]  data;
  logic              nd;
  logic [MWIDTH-1:0] m;

  modport master (output data, output nd, output m);
  modport slave  (input  data, input  nd, input  m);
endinterface

// File: rtl/nothing_msg_fifo.sv
// nothing_msg_fifo
//   Small synchronous FIFO holding samples waiting to be sent as debug
//   messages. Push and pop in the same cycle are accepted even when full.
//   Ports:
//     clk, rst_n    clock and asynchronous active-high reset
//     push, wdata   write request and data (ignored when full without pop)
//     pop, rdata    read request and head-of-queue data (show-ahead)
//     full, empty   occupancy flags
module nothing_msg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // When full, a simultaneous pop frees the head slot the write lands in.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/nothing_pipe.sv
// nothing_pipe
//   Registered pass-through for a sample stream (1-cycle latency, full
//   throughput, no transformation). With DEBUG=1 every accepted sample is
//   also logged as a header + payload message on out_msg, and loss of a
//   sample from the debug queue sets the sticky error flag.
//   Ports:
//     clk, rst_n   clock and asynchronous active-high reset (1 = reset)
//     in_if        input stream (slave)
//     out_if       registered output stream (master)
//     out_msg      debug message word, holds when out_msg_nd is low
//     out_msg_nd   debug message word valid
//     error        sticky debug queue overflow flag
//
//   Formatter FSM:
//     state   | meaning
//     IDLE    | no word on out_msg; waiting for a queued sample
//     HEADER  | header word on out_msg; payload word follows next cycle
//     PAYLOAD | payload word on out_msg; next header may follow directly
module nothing_pipe
  import nothing_pipe_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MWIDTH    = 1,
  parameter int MSG_WIDTH = 32,
  parameter int DEBUG     = 0,
  parameter int MSG_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nothing_pipe_if.slave        in_if,
  nothing_pipe_if.master       out_if,
  output logic [MSG_WIDTH-1:0] out_msg,
  output logic                 out_msg_nd,
  output logic                 error
);

  localparam int MSG_HDR_BIT = MSG_WIDTH - 1;

  logic [WIDTH-1:0]  out_data_q, out_data_d;
  logic              out_nd_q, out_nd_d;
  logic [MWIDTH-1:0] out_m_q, out_m_d;

  always_comb begin
    out_nd_d   = in_if.nd;
    out_data_d = out_data_q;
    out_m_d    = out_m_q;
    if (in_if.nd) begin
      out_data_d = in_if.data;
      out_m_d    = in_if.m;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_data_q <= '0;
      out_nd_q   <= 1'b0;
      out_m_q    <= '0;
    end else begin
      out_data_q <= out_data_d;
      out_nd_q   <= out_nd_d;
      out_m_q    <= out_m_d;
    end
  end

  assign out_if.data = out_data_q;
  assign out_if.nd   = out_nd_q;
  assign out_if.m    = out_m_q;

  if (DEBUG != 0) begin : g_debug
    localparam logic [MSG_WIDTH-1:0] HDR_WORD =
      MSG_WIDTH'(msg_header(6'(MSG_HDR_BIT), 8'd1));

    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [WIDTH-1:0]     fifo_head;
    msg_state_e           state_q, state_d;
    logic [WIDTH-1:0]     payload_q, payload_d;
    logic [MSG_WIDTH-1:0] msg_q, msg_d;
    logic                 msg_nd_q, msg_nd_d;
    logic                 error_q, error_d;

    nothing_msg_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (MSG_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_if.nd),
      .wdata (in_if.data),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
    );

    always_comb begin
      state_d   = state_q;
      payload_d = payload_q;
      msg_d     = msg_q;
      msg_nd_d  = 1'b0;
      fifo_pop  = 1'b0;
      // Sample lost from the message channel; the data path is unaffected.
      error_d   = error_q | (in_if.nd && fifo_full && !fifo_pop);
      case (state_q)
        IDLE, PAYLOAD: begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            payload_d = fifo_head;
            msg_d     = HDR_WORD;
            msg_nd_d  = 1'b1;
            state_d   = HEADER;
          end else begin
            state_d = IDLE;
          end
        end
        HEADER: begin
          msg_d    = {1'b0, (MSG_WIDTH-1)'(payload_q)};
          msg_nd_d = 1'b1;
          state_d  = PAYLOAD;
        end
        default: state_d = IDLE;
      endcase
      // Recomputed after the case so a pop issued this cycle is seen.
      error_d = error_q | (in_if.nd && fifo_full && !fifo_pop);
    end

    always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
        state_q   <= IDLE;
        payload_q <= '0;
        msg_q     <= '0;
        msg_nd_q  <= 1'b0;
        error_q   <= 1'b0;
      end else begin
        state_q   <= state_d;
        payload_q <= payload_d;
        msg_q     <= msg_d;
        msg_nd_q  <= msg_nd_d;
        error_q   <= error_d;
      end
    end

    assign out_msg    = msg_q;
    assign out_msg_nd = msg_nd_q;
    assign error      = error_q;
  end else begin : g_no_debug
    assign out_msg    = '0;
    assign out_msg_nd = 1'b0;
    assign error      = 1'b0;
  end

endmodule

// File: tb/tb_nothing_pipe.sv
// tb_nothing_pipe
//   Drives one stream into two nothing_pipe instances (DEBUG=1 and DEBUG=0)
//   and checks the registered data path and debug messages against
//   scoreboard queues filled when stimulus is driven.
module tb_nothing_pipe;
  localparam int WIDTH     = 32;
  localparam int MWIDTH    = 1;
  localparam int MSG_WIDTH = 32;
  localparam int MSG_DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  nothing_pipe_if #(.WIDTH(WIDTH), .MWIDTH(MWIDTH)) in_if ();
  nothing_pipe_if #(.WIDTH(WIDTH), .MWIDTH(MWIDTH)) out1_if ();
  nothing_pipe_if #(.WIDTH(WIDTH), .MWIDTH(MWIDTH)) out0_if ();

  logic [MSG_WIDTH-1:0] msg1, msg0;
  logic                 msg_nd1, msg_nd0, err1, err0;

  nothing_pipe #(
    .WIDTH(WIDTH), .MWIDTH(MWIDTH), .MSG_WIDTH(MSG_WIDTH),
    .DEBUG(1), .MSG_DEPTH(MSG_DEPTH)
  ) dut_dbg (
    .clk(clk), .rst_n(rst_n), .in_if(in_if), .out_if(out1_if),
    .out_msg(msg1), .out_msg_nd(msg_nd1), .error(err1)
  );

  nothing_pipe #(
    .WIDTH(WIDTH), .MWIDTH(MWIDTH), .MSG_WIDTH(MSG_WIDTH),
    .DEBUG(0), .MSG_DEPTH(MSG_DEPTH)
  ) dut_nodbg (
    .clk(clk), .rst_n(rst_n), .in_if(in_if), .out_if(out0_if),
    .out_msg(msg0), .out_msg_nd(msg_nd0), .error(err0)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_payload = 0;

  logic [WIDTH+MWIDTH-1:0] exp_d[$];
  logic [WIDTH-1:0]        exp_msg[$];

  logic                    nd_prev;
  logic [WIDTH+MWIDTH-1:0] last_dm = '0;
  logic [WIDTH-1:0]        mon_e;
  logic                    hdr_phase = 1'b0;
  logic                    msg_chk_en = 1'b1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; holds the inputs for one full cycle.
  task automatic drive(input logic nd, input logic [WIDTH-1:0] d, input logic [MWIDTH-1:0] m);
    in_if.nd   = nd;
    in_if.data = d;
    in_if.m    = m;
    if (nd && !rst_n) exp_d.push_back({d, m});
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) nd_prev <= 1'b0;
    else       nd_prev <= in_if.nd;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("out_nd", 64'(out1_if.nd), 64'(nd_prev));
      chk("out_nd_nodbg", 64'(out0_if.nd), 64'(nd_prev));
      if (nd_prev) begin
        chk("data_q_nonempty", 64'(exp_d.size() > 0), 64'(1));
        if (exp_d.size() > 0) last_dm = exp_d.pop_front();
      end
      chk("out_data", 64'(out1_if.data), 64'(last_dm[WIDTH+MWIDTH-1:MWIDTH]));
      chk("out_m", 64'(out1_if.m), 64'(last_dm[MWIDTH-1:0]));
      chk("out_data_nodbg", 64'(out0_if.data), 64'(last_dm[WIDTH+MWIDTH-1:MWIDTH]));
      chk("out_m_nodbg", 64'(out0_if.m), 64'(last_dm[MWIDTH-1:0]));
      if (msg_chk_en) begin
        if (msg_nd1) begin
          if (!hdr_phase) begin
            chk("msg_hdr", 64'(msg1), 64'(32'h8000_0001));
            hdr_phase = 1'b1;
          end else begin
            chk("msg_q_nonempty", 64'(exp_msg.size() > 0), 64'(1));
            if (exp_msg.size() > 0) begin
              mon_e = exp_msg.pop_front();
              chk("msg_payload", 64'(msg1), 64'({1'b0, mon_e[MSG_WIDTH-2:0]}));
            end
            hdr_phase = 1'b0;
            n_payload++;
          end
        end else if (hdr_phase) begin
          chk("msg_payload_missing", 64'(msg_nd1), 64'(1));
          hdr_phase = 1'b0;
        end
      end
      chk("nodbg_msg_nd", 64'(msg_nd0), 64'(0));
      chk("nodbg_msg", 64'(msg0), 64'(0));
      chk("nodbg_error", 64'(err0), 64'(0));
    end else begin
      hdr_phase = 1'b0;
      last_dm   = '0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic [WIDTH-1:0] d;
    logic nd;

    in_if.nd = 1'b0; in_if.data = '0; in_if.m = '0;

    // Reset held with the input toggling: every output stays at zero.
    for (int i = 0; i < 4; i++) begin
      in_if.nd   = i[0];
      in_if.data = 32'hdead_0000 + 32'(i);
      in_if.m    = 1'b1;
      @(negedge clk);
      chk("rst_out_data", 64'(out1_if.data), 64'(0));
      chk("rst_out_nd", 64'(out1_if.nd), 64'(0));
      chk("rst_out_m", 64'(out1_if.m), 64'(0));
      chk("rst_out_msg", 64'(msg1), 64'(0));
      chk("rst_out_msg_nd", 64'(msg_nd1), 64'(0));
      chk("rst_error", 64'(err1), 64'(0));
    end
    @(posedge clk); #1;
    in_if.nd = 1'b0;
    rst_n = 1'b0;
    drive(1'b0, '0, '0);
    drive(1'b0, '0, '0);

    // Single sample: data after k, header after k+1, payload after k+2.
    base = n_payload;
    exp_msg.push_back(32'h1234_5678);
    drive(1'b1, 32'h1234_5678, 1'b1);
    chk("single_out_data", 64'(out1_if.data), 64'(32'h1234_5678));
    chk("single_out_nd", 64'(out1_if.nd), 64'(1));
    chk("single_out_m", 64'(out1_if.m), 64'(1));
    chk("single_hdr_early", 64'(msg_nd1), 64'(0));
    drive(1'b0, '0, '0);
    chk("single_hdr", 64'(msg1), 64'(32'h8000_0001));
    chk("single_hdr_nd", 64'(msg_nd1), 64'(1));
    drive(1'b0, '0, '0);
    chk("single_payload", 64'(msg1), 64'(32'h1234_5678));
    chk("single_payload_nd", 64'(msg_nd1), 64'(1));
    drive(1'b0, '0, '0);
    chk("single_msg_idle", 64'(msg_nd1), 64'(0));
    chk("single_msg_hold", 64'(msg1), 64'(32'h1234_5678));

    // Hold: outputs keep the last sample while in_nd stays low.
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 32'hffff_ffff, 1'b0);
      chk("hold_out_nd", 64'(out1_if.nd), 64'(0));
      chk("hold_out_data", 64'(out1_if.data), 64'(32'h1234_5678));
      chk("hold_out_m", 64'(out1_if.m), 64'(1));
      chk("hold_msg_nd", 64'(msg_nd1), 64'(0));
    end
    chk("single_msg_count", 64'(n_payload - base), 64'(1));

    // Overflow: 9 back-to-back samples into a 4-deep queue, 9th dropped.
    base = n_payload;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) exp_msg.push_back(32'(i));
      drive(1'b1, 32'(i), i[0]);
      if (i == 8) chk("ovf_error_pre", 64'(err1), 64'(0));
    end
    chk("ovf_error_set", 64'(err1), 64'(1));
    for (int i = 0; i < 16; i++) drive(1'b0, '0, '0);
    chk("ovf_error_sticky", 64'(err1), 64'(1));
    chk("ovf_msg_count", 64'(n_payload - base), 64'(8));
    chk("ovf_msg_q_drained", 64'(exp_msg.size()), 64'(0));
    chk("ovf_data_q_drained", 64'(exp_d.size()), 64'(0));

    rst_n = 1'b1;
    drive(1'b0, '0, '0);
    chk("ovf_error_cleared", 64'(err1), 64'(0));
    rst_n = 1'b0;
    drive(1'b0, '0, '0);

    // Spaced stream: one sample every other cycle, messages back to back.
    base = n_payload;
    for (int i = 0; i < 20; i++) begin
      d = $urandom;
      exp_msg.push_back(d);
      drive(1'b1, d, 1'($urandom_range(0, 1)));
      drive(1'b0, '0, '0);
    end
    for (int i = 0; i < 4; i++) drive(1'b0, '0, '0);
    chk("spaced_msg_count", 64'(n_payload - base), 64'(20));
    chk("spaced_msg_q_drained", 64'(exp_msg.size()), 64'(0));
    chk("spaced_error", 64'(err1), 64'(0));

    // Reset while a header is on the bus aborts the message.
    base = n_payload;
    exp_msg.push_back(32'ha5a5_5a5a);
    drive(1'b1, 32'ha5a5_5a5a, 1'b0);
    drive(1'b0, '0, '0);
    chk("mid_hdr_nd", 64'(msg_nd1), 64'(1));
    rst_n = 1'b1;
    #1;
    chk("mid_rst_msg_nd", 64'(msg_nd1), 64'(0));
    chk("mid_rst_error", 64'(err1), 64'(0));
    chk("mid_rst_out_data", 64'(out1_if.data), 64'(0));
    exp_msg.delete();
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, '0);
      chk("mid_no_partial", 64'(msg_nd1), 64'(0));
    end
    chk("mid_msg_count", 64'(n_payload - base), 64'(0));

    // Random stream of 50 samples with random gaps; debug messages ignored.
    msg_chk_en = 1'b0;
    n = 0;
    while (n < 50) begin
      nd = 1'($urandom_range(0, 1));
      if (nd) n++;
      drive(nd, $urandom, 1'($urandom_range(0, 1)));
    end
    drive(1'b0, '0, '0);
    drive(1'b0, '0, '0);
    chk("rand_data_q_drained", 64'(exp_d.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nothing_pipe.md
Name: nothing_pipe

Overview:
- Registered pass-through stage for the sample stream: data plus new-data strobe plus metadata, 1-cycle latency, no transformation.
- Used as a null block and test fixture in streaming DSP chains.
- Optional debug channel (DEBUG=1) logs every accepted sample as a 2-word message on a message bus.
- Overflow of the debug queue is flagged on a sticky error output.

Parameters:
- WIDTH, 32, sample data width.
- MWIDTH, 1, metadata width.
- MSG_WIDTH, 32, message bus width (≥9).
- DEBUG, 0, 1 enables the message channel and error detection.
- MSG_DEPTH, 4, debug sample queue depth (power of two, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-high reset; asserted when 1. The name is kept per codebase convention.
- in_data  in  WIDTH  input sample.
- in_nd  in  1  input sample valid, one sample per cycle when high.
- in_m  in  MWIDTH  metadata accompanying in_data.
- out_data  out  WIDTH  registered sample.
- out_nd  out  1  output valid.
- out_m  out  MWIDTH  registered metadata.
- out_msg  out  MSG_WIDTH  debug message word.
- out_msg_nd  out  1  out_msg valid.
- error  out  1  sticky error flag.

Behaviour:
- Reset (async, rst_n=1):
  - Outputs: out_data=0, out_nd=0, out_m=0, out_msg=0, out_msg_nd=0, error=0.
  - State: queue emptied, FSM to IDLE.
  - Reset mid-message aborts the message; no partial words after release.
- Data path:
  - At each edge: out_nd <= in_nd.
  - When in_nd=1: out_data <= in_data and out_m <= in_m.
  - When in_nd=0: out_data and out_m hold their previous values.
  - Latency exactly 1 cycle; full throughput (in_nd high every cycle accepted, never back-pressured, never dropped).
- DEBUG=0: out_msg, out_msg_nd and error are tied to 0; no queue or FSM is synthesised.
- DEBUG=1, queue:
  - On every edge with in_nd=1, in_data is pushed into a MSG_DEPTH-entry FIFO.
  - Push and pop in the same cycle are allowed, including when full.
  - Push when full without a simultaneous pop: sample dropped from the message channel only (data path unaffected); error <= 1.
  - error stays 1 until reset.
- DEBUG=1, message FSM states IDLE, HEADER, PAYLOAD:
  - IDLE: if queue non-empty, pop head into a payload register, drive the header word, go to HEADER. Otherwise out_msg_nd=0.
  - HEADER (header word shown this cycle): drive the payload word, go to PAYLOAD.
  - PAYLOAD: if queue non-empty, pop and drive a new header, go to HEADER. Otherwise out_msg_nd=0, go to IDLE.
  - out_msg_nd=1 for exactly the cycles a word is presented; one message per 2 cycles maximum.
- Message format:
  - Header word: bit MSG_WIDTH-1 = 1, bits[7:0] = 1 (payload length), all other bits 0.
  - Payload word: bit MSG_WIDTH-1 = 0, bits[MSG_WIDTH-2:0] = sample, zero-extended or truncated to MSG_WIDTH-1 bits.
- Timing:
  - Sample captured at edge k: out_nd high after k; header valid after k+1; payload after k+2 (queue empty, FSM idle).
  - Out_msg holds its last value when out_msg_nd=0.

Decomposition:
- Shared package holds:
  - MSG_HDR_BIT (MSG_WIDTH-1), MSG_LEN_LSB=0 / MSG_LEN_MSB=7.
  - FSM state enum {IDLE, HEADER, PAYLOAD}.
  - Helper function building the header word from a length.
- One sub-module is natural: nothing_msg_fifo, a synchronous FIFO with push, pop, full, empty and simultaneous push/pop when full.
- The formatter FSM and data path stay in nothing_pipe, with a generate-if on DEBUG.

Test Plan:
- Reset: hold rst_n=1 with in_nd toggling -> all outputs 0. Assert rst_n mid-message -> out_msg_nd drops immediately, error=0.
- Single sample, DEBUG=1: in_data=0x12345678, in_m=1 at edge k:
  - out_data=0x12345678, out_nd=1, out_m=1 after edge k.
  - out_msg=0x80000001 with out_msg_nd=1 after edge k+1.
  - out_msg=0x12345678 after edge k+2; then out_msg_nd=0.
- Hold behaviour: in_nd=0 for 5 cycles after a sample -> out_nd=0 but out_data and out_m keep the last sample; no messages.
- Overflow, MSG_DEPTH=4: 9 consecutive samples 1..9 on in_nd ->
  - All 9 appear on out_data in order.
  - 8 messages (payloads 1..8) emitted.
  - error=1 after the 9th sample edge and stays 1.
- Spaced stream: samples every 2nd cycle for 20 samples -> 20 back-to-back messages, payloads match, error stays 0.
- DEBUG=0: random stream of 50 samples -> out_data, out_nd and out_m are the 1-cycle-delayed inputs; out_msg_nd and error stay 0.
